// File: rtl/button_peripheral_if.sv
// Processor-side register bus shared by the simple memory-mapped peripherals.
// The processor drives strobes, address and write data; the peripheral returns read data.
`timescale 1ns/1ps

interface button_peripheral_if;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output rd_en_i,
        output wr_en_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  rd_en_i,
        input  wr_en_i,
        input  addr_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/button_peripheral.sv
// Button/switch input peripheral: per-pin synchronizer, counter debouncer and
// rising-edge detector feeding sticky W1C event flags, a mask and a level interrupt.
`timescale 1ns/1ps

module button_peripheral #(
    parameter int NUM_INPUTS      = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    button_peripheral_if.slave    bus,
    input  logic [NUM_INPUTS-1:0] btn_i,
    output logic                  irq_o
);

    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] OFS_STATE = 4'h0;
    localparam logic [3:0] OFS_EVENT = 4'h4;
    localparam logic [3:0] OFS_MASK  = 4'h8;

    logic [NUM_INPUTS-1:0] sync1_reg;
    logic [NUM_INPUTS-1:0] sync2_reg;
    logic [NUM_INPUTS-1:0] stable_reg;
    logic [NUM_INPUTS-1:0] stable_next;
    logic [NUM_INPUTS-1:0] event_reg;
    logic [NUM_INPUTS-1:0] event_next;
    logic [NUM_INPUTS-1:0] mask_reg;
    logic [NUM_INPUTS-1:0] mask_next;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] clear_bits;
    logic                  irq_reg;
    logic                  irq_next;

    logic [3:0]  offset;
    logic        wr_event;
    logic        wr_mask;
    logic [31:0] rd_data;
    logic        unused_bus_bits;

    assign offset   = bus.addr_i[3:0];
    assign wr_event = bus.wr_en_i && (offset == OFS_EVENT);
    assign wr_mask  = bus.wr_en_i && (offset == OFS_MASK);

    // Only the low nibble of the address and the low NUM_INPUTS data bits matter.
    assign unused_bus_bits = ^{bus.addr_i[31:4], bus.data_i};

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-pin debouncer: stable flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the run.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             differ;
            logic             expired;

            assign differ   = sync2_reg[gi] ^ stable_reg[gi];
            assign expired  = (cnt_reg == CNT_LAST);
            assign cnt_next = (!differ || expired) ? '0 : cnt_reg + 1'b1;
            assign stable_next[gi] = (differ && expired) ? sync2_reg[gi] : stable_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign rise       = stable_next & ~stable_reg;
    assign clear_bits = wr_event ? bus.data_i[NUM_INPUTS-1:0] : '0;
    // A rise on the same edge as its clear wins, so no press is ever lost.
    assign event_next = (event_reg & ~clear_bits) | rise;
    assign mask_next  = wr_mask ? bus.data_i[NUM_INPUTS-1:0] : mask_reg;
    assign irq_next   = |(event_next & mask_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_reg <= '0;
            event_reg  <= '0;
            mask_reg   <= '0;
            irq_reg    <= 1'b0;
        end else begin
            stable_reg <= stable_next;
            event_reg  <= event_next;
            mask_reg   <= mask_next;
            irq_reg    <= irq_next;
        end
    end

    assign irq_o = irq_reg;

    always_comb begin
        rd_data = 32'd0;
        if (bus.rd_en_i) begin
            case (offset)
                OFS_STATE: rd_data = 32'(stable_reg);
                OFS_EVENT: rd_data = 32'(event_reg);
                OFS_MASK:  rd_data = 32'(mask_reg);
                default:   rd_data = 32'd0;
            endcase
        end
    end

    assign bus.data_o = rd_data;

endmodule

// File: tb/tb_button_peripheral.sv
// Directed bench for button_peripheral with DEBOUNCE_CYCLES=4, NUM_INPUTS=8.
`timescale 1ns/1ps

module tb_button_peripheral;

    logic       clk;
    logic       rst;
    logic [7:0] btn_i;
    logic       irq_o;

    int vec_count;
    int miscompare_count;

    button_peripheral_if bus ();

    button_peripheral #(
        .NUM_INPUTS      (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .btn_i (btn_i),
        .irq_o (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.addr_i  = addr;
        bus.data_i  = data;
        bus.wr_en_i = 1'b1;
        tick();
        bus.wr_en_i = 1'b0;
        bus.addr_i  = 32'd0;
        bus.data_i  = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.addr_i  = addr;
        bus.rd_en_i = 1'b1;
        #1;
        data = bus.data_o;
        bus.rd_en_i = 1'b0;
        bus.addr_i  = 32'd0;
    endtask

    task automatic do_reset();
        btn_i = 8'h00;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        vec_count        = 0;
        miscompare_count = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        btn_i       = 8'h00;
        bus.rd_en_i = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.addr_i  = 32'd0;
        bus.data_i  = 32'd0;

        // Reset values, read while reset is still asserted
        repeat (2) @(posedge clk);
        #1;
        bus_read(32'h0, rd); check_result("rst_state", rd, 32'h0);
        bus_read(32'h4, rd); check_result("rst_event", rd, 32'h0);
        bus_read(32'h8, rd); check_result("rst_mask", rd, 32'h0);
        check_result("rst_irq", {31'd0, irq_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Clean press on bit0
        bus_write(32'h8, 32'h1);
        btn_i = 8'h01;
        repeat (5) tick();
        bus_read(32'h0, rd); check_result("press_state_e4", rd, 32'h0);
        bus_read(32'h4, rd); check_result("press_event_e4", rd, 32'h0);
        check_result("press_irq_e4", {31'd0, irq_o}, 32'h0);
        tick();
        bus_read(32'h0, rd); check_result("press_state_e5", rd, 32'h1);
        bus_read(32'h4, rd); check_result("press_event_e5", rd, 32'h1);
        tick();
        check_result("press_irq_e6", {31'd0, irq_o}, 32'h1);
        check_result("idle_data_o", bus.data_o, 32'h0);

        // Mask keeps only NUM_INPUTS bits
        bus_write(32'h8, 32'hFFFF_FFA5);
        bus_read(32'h8, rd); check_result("mask_readback", rd, 32'hA5);

        // Bounce on bit1: 1,0,1,0 then hold 1
        do_reset();
        btn_i = 8'h02; tick();
        btn_i = 8'h00; tick();
        btn_i = 8'h02; tick();
        btn_i = 8'h00; tick();
        btn_i = 8'h02; tick();
        repeat (4) tick();
        bus_read(32'h0, rd); check_result("bounce_state_e4", rd, 32'h0);
        bus_read(32'h4, rd); check_result("bounce_event_e4", rd, 32'h0);
        tick();
        bus_read(32'h0, rd); check_result("bounce_state_e5", rd, 32'h2);
        bus_read(32'h4, rd); check_result("bounce_event_e5", rd, 32'h2);
        bus_write(32'h4, 32'h2);
        repeat (4) tick();
        bus_read(32'h4, rd); check_result("bounce_event_once", rd, 32'h0);
        btn_i = 8'h00;
        repeat (8) tick();
        bus_read(32'h0, rd); check_result("release_state", rd, 32'h0);
        bus_read(32'h4, rd); check_result("release_no_event", rd, 32'h0);

        // W1C behaviour
        do_reset();
        bus_write(32'h8, 32'hFF);
        btn_i = 8'h05;
        repeat (7) tick();
        bus_read(32'h4, rd); check_result("w1c_setup_event", rd, 32'h5);
        check_result("w1c_setup_irq", {31'd0, irq_o}, 32'h1);
        bus_write(32'h4, 32'h1);
        bus_read(32'h4, rd); check_result("w1c_clear_bit0", rd, 32'h4);
        check_result("w1c_irq_held", {31'd0, irq_o}, 32'h1);
        bus_write(32'h4, 32'h4);
        tick();
        check_result("w1c_irq_drop", {31'd0, irq_o}, 32'h0);
        bus_read(32'h4, rd); check_result("w1c_clear_bit2", rd, 32'h0);
        bus_write(32'h0, 32'hFF);
        bus_read(32'h0, rd); check_result("state_write_ignored", rd, 32'h5);

        // Collision: clear of bit2 on the edge it rises, bit0 clears normally
        do_reset();
        btn_i = 8'h01;
        repeat (7) tick();
        bus_read(32'h4, rd); check_result("coll_setup_event", rd, 32'h1);
        btn_i = 8'h05;
        tick();
        repeat (4) tick();
        bus_write(32'h4, 32'h5);
        bus_read(32'h0, rd); check_result("coll_state", rd, 32'h5);
        bus_read(32'h4, rd); check_result("coll_event", rd, 32'h4);

        // Async reset in the middle of a debounce run
        do_reset();
        btn_i = 8'h80;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        bus_read(32'h0, rd); check_result("midrst_state_async", rd, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_read(32'h0, rd); check_result("midrst_state_held", rd, 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        bus_read(32'h0, rd); check_result("midrst_state_f4", rd, 32'h0);
        tick();
        bus_read(32'h0, rd); check_result("midrst_state_f5", rd, 32'h80);
        bus_read(32'h4, rd); check_result("midrst_event", rd, 32'h80);
        bus_read(32'hC, rd); check_result("unmapped_read", rd, 32'h0);
        bus_write(32'hC, 32'hFF);
        bus_read(32'h8, rd); check_result("unmapped_write", rd, 32'h0);
        check_result("masked_irq", {31'd0, irq_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule

// File: doc/button_peripheral.md
Name: button_peripheral

Overview:
- Memory-mapped input peripheral: the processor reads external buttons/switches through it. It is the inbound counterpart of the LED output peripheral and sits on the same simple processor bus.
- Per input bit: 2-flop synchronizer, then counter-based debouncer, then rising-edge detector feeding a sticky, write-1-to-clear event register.
- Drives a level interrupt from the masked pending events.

Parameters:
- NUM_INPUTS, 8: number of input pins; 1..32.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from the stable value before the stable value flips; >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rd_en_i  input  1  processor read strobe
- wr_en_i  input  1  processor write strobe
- addr_i  input  32  byte address; only addr_i[3:0] decoded
- data_i  input  32  write data
- data_o  output  32  read data, combinational
- btn_i  input  NUM_INPUTS  raw asynchronous external inputs
- irq_o  output  1  interrupt, high while any (event & mask) bit set

Behaviour:
- Reset (rst=1, async): sync flops, stable, event, mask and counters all 0. Outputs: irq_o=0; data_o=0 unless a read is active, in which case it shows register values (all 0).
- Register map (offset = addr_i[3:0]):
  - 0x0 STATE: read-only; bits [NUM_INPUTS-1:0] = debounced stable value.
  - 0x4 EVENT: read returns sticky rising-edge flags. A write clears each bit where data_i is 1 (W1C).
  - 0x8 MASK: read/write; the write stores data_i[NUM_INPUTS-1:0].
  - Other offsets: read 0, writes ignored. Writes to STATE are ignored.
- Read path: data_o = zero-extended register when rd_en_i and the offset matches, else 32'b0. No read side effects.
- Write path: takes effect on the clk edge where wr_en_i=1.
- Synchronizer: sync1 <= btn_i; sync2 <= sync1. Reset value 0.
- Debounce, per bit, on each clk edge:
  - cnt width is $clog2(DEBOUNCE_CYCLES), minimum 1.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2; cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the stable value restarts the count.
- Latency: a clean level change sampled into sync1 at edge E flips stable at edge E+DEBOUNCE_CYCLES+1.
- Edge detect: event bit set on the edge where stable goes 0->1. Falling edges set nothing.
- Simultaneous set and W1C clear of the same bit in one cycle: set wins, bit stays 1. Clear of other bits proceeds normally.
- irq_o: registered, irq_o <= |(event_next & mask_next). It asserts the cycle after the event or mask update and deasserts the cycle after a clear or unmask. No glitches.
- Reset mid-debounce: counters zero immediately; a held input re-debounces from scratch after rst falls.
- Inputs above NUM_INPUTS read as 0 in every register.

Test Plan (DEBOUNCE_CYCLES=4, NUM_INPUTS=8):
- Reset then read 0x0, 0x4, 0x8 -> all 0x00000000; irq_o=0; data_o=0 with rd_en_i=0.
- Clean press:
  - Stimulus: btn_i=8'h01 held from edge E.
  - STATE reads 0x01 from E+5 onward, 0x00 before.
  - EVENT bit0=1 at E+5.
  - With MASK=0x01, irq_o=1 at E+6.
- Bounce:
  - Stimulus: bit1 toggles 1,0,1,0 each cycle, then holds 1.
  - STATE bit1 flips only 5 edges after the final stable 1.
  - EVENT=0x02 exactly once.
  - No flag on release.
- W1C:
  - Setup: EVENT=0x05, MASK=0xFF, irq_o=1.
  - Write 0x4 with 0x01 -> EVENT=0x04, irq_o stays 1.
  - Write 0x04 -> EVENT=0x00, irq_o=0 next cycle.
  - Write to 0x0 -> STATE unchanged.
- Collision: W1C of bit2 on the same edge that bit2 rises -> EVENT bit2 remains 1.
- Async reset mid-count:
  - Stimulus: assert rst two cycles into a debounce, release, keep btn_i=0x80.
  - STATE=0 during reset.
  - STATE=0x80 exactly DEBOUNCE_CYCLES+1 edges after sync1 first samples 1 after release.
  - Read of 0xC returns 0.
